// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS32 front end.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    // One fetched word together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Shifting fetch queue: entry 0 is always the head, so decode sees flopped outputs.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     pushData,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             headValid,
    output fetch_entry_t     head
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    fetch_entry_t     entries [DEPTH];
    logic [CNT_W-1:0] countNext;
    logic [CNT_W-1:0] wrSlot;

    always_comb begin
        countNext = count + CNT_W'(push) - CNT_W'(pop);
        wrSlot    = count - CNT_W'(pop);
    end

    // A pop shifts everything down; a push then lands just past the survivors.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            headValid <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '{pc: '0, instr: NOP_INSTR};
            end
        end else if (flush) begin
            count     <= '0;
            headValid <= 1'b0;
        end else begin
            if (pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    entries[i] <= entries[i + 1];
                end
            end
            if (push) begin
                entries[IDX_W'(wrSlot)] <= pushData;
            end
            count     <= countNext;
            headValid <= (countNext != '0);
        end
    end

    assign head = entries[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, imem req/ack FSM and the decode-facing queue.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump_en,
    input  logic [XLEN-1:0]    jump_target,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [XLEN-1:0]    id_pc,
    output logic [XLEN-1:0]    id_pc_plus4
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_t     state, stateNext;
    logic [XLEN-1:0]  fetchPc, fetchPcNext;
    logic [XLEN-1:0]  reqPc, reqPcNext;
    logic [XLEN-1:0]  jumpPc;
    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occNext;
    logic             push, pop, room;
    logic             unusedJumpBits;
    fetch_entry_t     pushData, head;

    assign jumpPc         = {jump_target[XLEN-1:2], 2'b00};
    assign unusedJumpBits = ^jump_target[1:0];

    always_comb begin
        push    = (state == REQ) && imem_ack && !jump_en;
        pop     = id_valid && id_ready && !jump_en;
        occNext = OCC_W'(count) + OCC_W'(push) - OCC_W'(pop);
        room    = occNext < OCC_W'(DEPTH);
    end

    // Issuing a request latches its address into reqPc and advances fetchPc past it.
    always_comb begin
        stateNext   = state;
        fetchPcNext = fetchPc;
        reqPcNext   = reqPc;
        case (state)
            IDLE: begin
                if (jump_en) begin
                    stateNext   = REQ;
                    reqPcNext   = jumpPc;
                    fetchPcNext = jumpPc + XLEN'(4);
                end else if (room) begin
                    stateNext   = REQ;
                    reqPcNext   = fetchPc;
                    fetchPcNext = fetchPc + XLEN'(4);
                end
            end
            REQ: begin
                if (jump_en) begin
                    if (imem_ack) begin
                        reqPcNext   = jumpPc;
                        fetchPcNext = jumpPc + XLEN'(4);
                    end else begin
                        stateNext   = DROP;
                        fetchPcNext = jumpPc;
                    end
                end else if (imem_ack) begin
                    if (room) begin
                        reqPcNext   = fetchPc;
                        fetchPcNext = fetchPc + XLEN'(4);
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            DROP: begin
                if (imem_ack) begin
                    stateNext = REQ;
                    if (jump_en) begin
                        reqPcNext   = jumpPc;
                        fetchPcNext = jumpPc + XLEN'(4);
                    end else begin
                        reqPcNext   = fetchPc;
                        fetchPcNext = fetchPc + XLEN'(4);
                    end
                end else if (jump_en) begin
                    fetchPcNext = jumpPc;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            reqPc   <= RESET_PC;
        end else begin
            state   <= stateNext;
            fetchPc <= fetchPcNext;
            reqPc   <= reqPcNext;
        end
    end

    assign pushData = '{pc: reqPc, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pushData (pushData),
        .pop      (pop),
        .flush    (jump_en),
        .count    (count),
        .headValid(id_valid),
        .head     (head)
    );

    assign imem_req    = (state != IDLE);
    assign imem_addr   = reqPc;
    assign id_instr    = head.instr;
    assign id_pc       = head.pc;
    assign id_pc_plus4 = head.pc + XLEN'(4);

endmodule
